axi_lite_arbiter: RTL
=====================

# axi_lite_arbiter

Two-master, one-slave AXI-lite arbiter that shares the single SRAM port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It sits between both pipeline stages and the SRAM AXI-lite slave. It grants one complete transaction at a time, from address phase through response. Arbitration favours the LSU, with an alternation guard so fetch cannot starve.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `if_araddr` in ADDR_W / `if_arvalid` in 1 / `if_arready` out 1: IFU read address channel.
- `if_rdata` out DATA_W / `if_rvalid` out 1 / `if_rready` in 1: IFU read data channel.
- `ls_araddr` in ADDR_W / `ls_arvalid` in 1 / `ls_arready` out 1: LSU read address channel.
- `ls_rdata` out DATA_W / `ls_rvalid` out 1 / `ls_rready` in 1: LSU read data channel.
- `ls_waddr` in ADDR_W / `ls_wdata` in DATA_W / `ls_w_shifter` in 8 / `ls_w_DWHB` in 8 / `ls_wvalid` in 1 / `ls_wready` out 1: LSU combined write address+data channel.
- `ls_bvalid` out 1 / `ls_bready` in 1: LSU write response.
- `m_araddr`, `m_arvalid`, `m_arready`, `m_rdata`, `m_rvalid`, `m_rready`, `m_waddr`, `m_wdata`, `m_w_shifter`, `m_w_DWHB`, `m_wvalid`, `m_wready`, `m_bvalid`, `m_bready`: slave-side channels, with the same widths and directions mirrored.

## Operation
- FSM states: IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_W, LS_B.
- In IDLE, arbitration is evaluated every cycle on `if_arvalid`, `ls_arvalid` and `ls_wvalid`:
  - LSU request beats IFU request, unless `last_ls`=1 and `if_arvalid`=1, in which case IFU wins.
  - Within the LSU, write (LS_W) beats read (LS_AR).
  - `last_ls` is set on every LSU grant and cleared on every IFU grant.
- Transitions:
  - IF_AR→IF_R on `m_arready`.
  - IF_R→IDLE on `m_rvalid&&if_rready`.
  - LS_AR→LS_R on `m_arready`.
  - LS_R→IDLE on `m_rvalid&&ls_rready`.
  - LS_W→LS_B on `m_wready`.
  - LS_B→IDLE on `m_bvalid&&ls_bready`.
- Forwarding:
  - Only the granted master's request fields are muxed to `m_*`. In all other states `m_*valid`=0 and `m_*addr`/data/mask=0.
  - `m_arready`, `m_wready` and `m_rvalid`, `m_bvalid` are routed combinationally to the granted master only. `m_rdata` is broadcast to both `if_rdata` and `ls_rdata`.
  - Non-granted masters see `*ready`=0 and `*valid`=0.
- `m_rready`/`m_bready` are forwarded from the granted master in R/B states and are 0 elsewhere.
- A master must hold its request stable until accepted; the arbiter never drops a granted request.
- Async reset (`resetn`=0, at any time including mid-transaction):
  - FSM goes to IDLE and `last_ls` to 0.
  - All outputs go to 0 immediately.
  - An in-flight slave transaction is abandoned; the SRAM shares `resetn`.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives slave `m_arvalid`/`m_wvalid`=1 in cycle N+1. Minimum one bubble per transaction.
- Response path is zero-latency: `if_rvalid`/`ls_rvalid`/`ls_bvalid` follow `m_*valid` in the same cycle.
- Back-to-back throughput: IDLE is re-entered after the response handshake, so the next grant is evaluated in that IDLE cycle. Minimum 3 cycles per single-cycle-slave transaction (IDLE, AR/W, R/B).
- Simultaneous IFU and LSU requests in IDLE resolve per the priority rule above. The loser's `*ready` stays 0 until its own grant.
- A request deasserted while not granted (pipeline cancel) is legal and is simply not granted.

## Structure
- Shared header `axi_arb_defs.vh` holds the state encodings (3-bit localparams) and the master IDs (`MID_IF`=0, `MID_LS`=1).
- One sub-module: `arb_pick`, the combinational priority/alternation decision (inputs: three valids and `last_ls`; outputs: next state and grant). This is unit-testable on its own.
- Top level holds the FSM register, the `last_ls` flop and the channel muxes.

## Test plan
- Reset: hold `resetn`=0 with every input valid high → all outputs 0. Release → state IDLE, first grant in the following cycle.
- IFU alone: `if_araddr`=0x8000_0000 with slave returning `m_rdata`=0x0000_0013_0000_0093 after 2 cycles → `m_araddr`=0x8000_0000 in cycle N+1. `if_rvalid`=1 with that data. `ls_rvalid` stays 0.
- Simultaneous: `if_arvalid` and `ls_arvalid` high in the same IDLE cycle → LSU granted first, IFU second. Then present both again → IFU granted next (alternation).
- LSU write and read together: `ls_waddr`=0x8000_1000, `ls_wdata`=0xDEAD_BEEF, `ls_w_DWHB`=0x0F → write is forwarded first. `ls_bvalid` pulses, then the read is granted.
- Backpressure: `if_rready`=0 for 3 cycles while `m_rvalid`=1 → FSM holds in IF_R, `m_rready`=0, and no new grant occurs.
- Mid-transaction reset: drive `resetn`=0 while in LS_B → all outputs 0 asynchronously. After release, a pending `if_arvalid` is granted.

Source files
------------

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-master AXI-lite arbiter:
// the transaction FSM encoding and the master identifiers.
package axi_lite_arbiter_pkg;

    // One state per channel phase of the currently granted master.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_AR = 3'd1,
        ST_IF_R  = 3'd2,
        ST_LS_AR = 3'd3,
        ST_LS_R  = 3'd4,
        ST_LS_W  = 3'd5,
        ST_LS_B  = 3'd6
    } arb_state_e;

    // Master identifiers; the LSU id doubles as the value stored in last_ls.
    localparam logic MID_IF = 1'b0;
    localparam logic MID_LS = 1'b1;

endpackage

// File: rtl/axi_lite_arbiter_pick.sv
// Combinational grant decision evaluated while the arbiter is idle.
// LSU beats IFU unless the previous grant went to the LSU and the IFU is
// waiting; inside the LSU a write beats a read.
module axi_lite_arbiter_pick
    import axi_lite_arbiter_pkg::*;
(
    input  logic       if_arvalid_i,
    input  logic       ls_arvalid_i,
    input  logic       ls_wvalid_i,
    input  logic       last_ls_i,
    output arb_state_e next_state_o,
    output logic       grant_o,
    output logic       grant_mid_o
);

    // Priority with alternation guard so fetch cannot be starved.
    always_comb begin
        next_state_o = ST_IDLE;
        grant_o      = 1'b0;
        grant_mid_o  = MID_IF;
        if ((ls_arvalid_i || ls_wvalid_i) && !(last_ls_i && if_arvalid_i)) begin
            grant_o      = 1'b1;
            grant_mid_o  = MID_LS;
            next_state_o = ls_wvalid_i ? ST_LS_W : ST_LS_AR;
        end else if (if_arvalid_i) begin
            grant_o      = 1'b1;
            grant_mid_o  = MID_IF;
            next_state_o = ST_IF_AR;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One complete transaction is owned at a time, from address phase through
// response; only the owner's channels are connected to the slave port.
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    // IFU read
    input  logic [ADDR_W-1:0] if_araddr,
    input  logic              if_arvalid,
    output logic              if_arready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              if_rready,
    // LSU read
    input  logic [ADDR_W-1:0] ls_araddr,
    input  logic              ls_arvalid,
    output logic              ls_arready,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_rvalid,
    input  logic              ls_rready,
    // LSU write (address and data combined)
    input  logic [ADDR_W-1:0] ls_waddr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_w_shifter,
    input  logic [7:0]        ls_w_DWHB,
    input  logic              ls_wvalid,
    output logic              ls_wready,
    output logic              ls_bvalid,
    input  logic              ls_bready,
    // Slave port
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [7:0]        m_w_shifter,
    output logic [7:0]        m_w_DWHB,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic              m_bvalid,
    output logic              m_bready
);

    arb_state_e state_q;
    logic       last_ls_q;

    arb_state_e pick_state;
    logic       pick_grant;
    logic       pick_mid;

    axi_lite_arbiter_pick u_pick (
        .if_arvalid_i (if_arvalid),
        .ls_arvalid_i (ls_arvalid),
        .ls_wvalid_i  (ls_wvalid),
        .last_ls_i    (last_ls_q),
        .next_state_o (pick_state),
        .grant_o      (pick_grant),
        .grant_mid_o  (pick_mid)
    );

    // Transaction FSM plus the alternation flag, updated only on a grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            last_ls_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_grant) begin
                        state_q   <= pick_state;
                        last_ls_q <= pick_mid;
                    end
                end
                ST_IF_AR: if (m_arready)              state_q <= ST_IF_R;
                ST_IF_R:  if (m_rvalid && if_rready)  state_q <= ST_IDLE;
                ST_LS_AR: if (m_arready)              state_q <= ST_LS_R;
                ST_LS_R:  if (m_rvalid && ls_rready)  state_q <= ST_IDLE;
                ST_LS_W:  if (m_wready)               state_q <= ST_LS_B;
                ST_LS_B:  if (m_bvalid && ls_bready)  state_q <= ST_IDLE;
                default:                              state_q <= ST_IDLE;
            endcase
        end
    end

    logic st_if_ar, st_if_r, st_ls_ar, st_ls_r, st_ls_w, st_ls_b;
    assign st_if_ar = (state_q == ST_IF_AR);
    assign st_if_r  = (state_q == ST_IF_R);
    assign st_ls_ar = (state_q == ST_LS_AR);
    assign st_ls_r  = (state_q == ST_LS_R);
    assign st_ls_w  = (state_q == ST_LS_W);
    assign st_ls_b  = (state_q == ST_LS_B);

    // Request side: valids come from the state so a granted request is never dropped.
    assign m_arvalid   = st_if_ar | st_ls_ar;
    assign m_araddr    = st_if_ar ? if_araddr : (st_ls_ar ? ls_araddr : '0);
    assign m_wvalid    = st_ls_w;
    assign m_waddr     = st_ls_w ? ls_waddr     : '0;
    assign m_wdata     = st_ls_w ? ls_wdata     : '0;
    assign m_w_shifter = st_ls_w ? ls_w_shifter : '0;
    assign m_w_DWHB    = st_ls_w ? ls_w_DWHB    : '0;

    assign if_arready  = st_if_ar & m_arready;
    assign ls_arready  = st_ls_ar & m_arready;
    assign ls_wready   = st_ls_w  & m_wready;

    // Response side: zero-latency routing to the owner only.
    assign if_rvalid   = st_if_r & m_rvalid;
    assign ls_rvalid   = st_ls_r & m_rvalid;
    assign ls_bvalid   = st_ls_b & m_bvalid;
    assign m_rready    = (st_if_r & if_rready) | (st_ls_r & ls_rready);
    assign m_bready    = st_ls_b & ls_bready;

    // Read data is broadcast; gated by reset so every output is 0 while held.
    assign if_rdata    = resetn ? m_rdata : '0;
    assign ls_rdata    = resetn ? m_rdata : '0;

endmodule
